// File: rtl/alu_result_display.sv
// alu_result_display
//   Consumer end of the ALU result path. A strobed unsigned result is converted
//   to two BCD digits by a sequential double-dabble engine (one shift per clock).
//   The digits then drive a time-multiplexed 2-digit 7-segment display.
//
// Ports
//   i_clk           system clock
//   i_rst_n         synchronous active-low reset
//   i_ena           design enable; low freezes all state, masks done/overrun
//   i_result_in     unsigned ALU result (RES_W bits)
//   i_result_valid  one-cycle strobe qualifying i_result_in
//   o_busy          high while a conversion is in flight (CONV or LOAD)
//   o_done          one-cycle pulse in the cycle new digits are loaded
//   o_overrun       one-cycle pulse after a strobe that arrived while busy
//   o_bcd_tens      displayed tens digit
//   o_bcd_ones      displayed ones digit
//   o_seg           segment drive {g,f,e,d,c,b,a}
//   o_dig_sel       one-hot digit select, 01 = ones, 10 = tens
module alu_result_display #(
    parameter int unsigned RES_W          = 6,
    parameter int unsigned REFRESH_DIV    = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ena,
    input  logic [RES_W-1:0] i_result_in,
    input  logic             i_result_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overrun,
    output logic [3:0]       o_bcd_tens,
    output logic [3:0]       o_bcd_ones,
    output logic [6:0]       o_seg,
    output logic [1:0]       o_dig_sel
);

    // RES_W <= 6, so a 3-bit iteration counter always suffices.
    localparam int unsigned CNT_W = 3;
    localparam int unsigned REF_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StLoad
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [RES_W-1:0]   r_shift;
    logic [7:0]         r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_tens;
    logic [3:0]         r_ones;
    logic               r_overrun;
    logic [REF_W-1:0]   r_ref_cnt;
    logic [1:0]         r_dig_sel;

    logic [7:0]         w_acc_adj;
    logic [8+RES_W-1:0] w_dabble;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg_dec;
    logic [6:0]         w_seg;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else if (i_ena) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_result_valid) w_state_next = StConv;
            StConv: if (r_cnt == CNT_W'(RES_W - 1)) w_state_next = StLoad;
            StLoad: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Double-dabble step: add 3 to any nibble >= 5, then shift the
    // {accumulator, shift register} pair left by one.
    // ------------------------------------------------------------------
    always_comb begin
        w_acc_adj = r_acc;
        if (r_acc[3:0] >= 4'd5) w_acc_adj[3:0] = r_acc[3:0] + 4'd3;
        if (r_acc[7:4] >= 4'd5) w_acc_adj[7:4] = r_acc[7:4] + 4'd3;
    end

    assign w_dabble = {w_acc_adj, r_shift} << 1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_tens    <= '0;
            r_ones    <= '0;
            r_overrun <= 1'b0;
        end else if (i_ena) begin
            // A strobe in CONV or LOAD is dropped; only flag it.
            r_overrun <= i_result_valid && (r_state != StIdle);
            unique case (r_state)
                StIdle: begin
                    if (i_result_valid) begin
                        r_shift <= i_result_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                StConv: begin
                    r_acc   <= w_dabble[8+RES_W-1:RES_W];
                    r_shift <= w_dabble[RES_W-1:0];
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                StLoad: begin
                    r_tens <= r_acc[7:4];
                    r_ones <= r_acc[3:0];
                end
                default: ;
            endcase
        end else begin
            // No stale overrun pulse may surface once enable returns.
            r_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display refresh: free-running, independent of the conversion FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ref_cnt <= '0;
            r_dig_sel <= 2'b01;
        end else if (i_ena) begin
            if (r_ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
                r_ref_cnt <= '0;
                r_dig_sel <= ~r_dig_sel;
            end else begin
                r_ref_cnt <= r_ref_cnt + REF_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment decode (combinational from dig_sel and digit registers)
    // ------------------------------------------------------------------
    assign w_digit = r_dig_sel[1] ? r_tens : r_ones;

    always_comb begin
        w_seg_dec = 7'h00;
        case (w_digit)
            4'd0: w_seg_dec = 7'h3F;
            4'd1: w_seg_dec = 7'h06;
            4'd2: w_seg_dec = 7'h5B;
            4'd3: w_seg_dec = 7'h4F;
            4'd4: w_seg_dec = 7'h66;
            4'd5: w_seg_dec = 7'h6D;
            4'd6: w_seg_dec = 7'h7D;
            4'd7: w_seg_dec = 7'h07;
            4'd8: w_seg_dec = 7'h7F;
            4'd9: w_seg_dec = 7'h6F;
            default: w_seg_dec = 7'h00;
        endcase
    end

    // Leading-zero blanking applies to the tens position only.
    assign w_seg = (r_dig_sel[1] && (r_tens == 4'd0)) ? 7'h00 : w_seg_dec;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_busy     = (r_state != StIdle);
    assign o_done     = (r_state == StLoad) && i_ena;
    assign o_overrun  = r_overrun && i_ena;
    assign o_bcd_tens = r_tens;
    assign o_bcd_ones = r_ones;
    assign o_seg      = SEG_ACTIVE_LOW ? ~w_seg : w_seg;
    assign o_dig_sel  = SEG_ACTIVE_LOW ? ~r_dig_sel : r_dig_sel;

endmodule

// File: tb/tb_alu_result_display.sv
// tb_alu_result_display
//   Directed bench for alu_result_display with RES_W=6, REFRESH_DIV=4.
//   Inputs are driven 1 time unit after each rising edge and outputs are
//   checked at that same point, so "cycle n" is the interval after edge n.
module tb_alu_result_display;

    localparam int unsigned RES_W = 6;
    localparam int unsigned REFRESH_DIV = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_ena = 1'b1;
    logic [RES_W-1:0] i_result_in = '0;
    logic             i_result_valid = 1'b0;
    logic             o_busy;
    logic             o_done;
    logic             o_overrun;
    logic [3:0]       o_bcd_tens;
    logic [3:0]       o_bcd_ones;
    logic [6:0]       o_seg;
    logic [1:0]       o_dig_sel;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_display #(
        .RES_W         (RES_W),
        .REFRESH_DIV   (REFRESH_DIV),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_ena         (i_ena),
        .i_result_in   (i_result_in),
        .i_result_valid(i_result_valid),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overrun     (o_overrun),
        .o_bcd_tens    (o_bcd_tens),
        .o_bcd_ones    (o_bcd_ones),
        .o_seg         (o_seg),
        .o_dig_sel     (o_dig_sel)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until the requested digit is selected, bounded.
    task automatic wait_sel(input string tag, input logic [1:0] sel);
        bit found = 1'b0;
        for (int i = 0; i < 4 * REFRESH_DIV; i++) begin
            if (o_dig_sel == sel) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 8'(found), 8'd1);
    endtask

    // Strobe a value and run to the first cycle the new digits are visible.
    task automatic convert(input logic [RES_W-1:0] val);
        i_result_in    = val;
        i_result_valid = 1'b1;
        step();
        i_result_valid = 1'b0;
        for (int c = 1; c <= RES_W + 1; c++) step();
    endtask

    initial begin
        // ---------------- Reset ----------------
        i_rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", 8'(o_busy), 8'd0);
        chk("rst_done", 8'(o_done), 8'd0);
        chk("rst_overrun", 8'(o_overrun), 8'd0);
        chk("rst_tens", 8'(o_bcd_tens), 8'd0);
        chk("rst_ones", 8'(o_bcd_ones), 8'd0);
        chk("rst_dig_sel", 8'(o_dig_sel), 8'h01);
        chk("rst_seg", 8'(o_seg), 8'h3F);

        // ---------------- Convert 63 + refresh sequence ----------------
        // Refresh counter is 0 in cycle k=0; strobe 63 in that same cycle.
        i_rst_n = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            i_result_in    = 6'd63;
            i_result_valid = (k == 0);
            chk($sformatf("c63_dig_sel_k%0d", k), 8'(o_dig_sel),
                ((k / 4) % 2 == 1) ? 8'h02 : 8'h01);
            chk($sformatf("c63_busy_k%0d", k), 8'(o_busy), 8'((k >= 1) && (k <= 7)));
            chk($sformatf("c63_done_k%0d", k), 8'(o_done), 8'(k == 7));
            if (k == 4) chk("blank_tens_after_rst", 8'(o_seg), 8'h00);
            if (k == 8) begin
                chk("c63_tens", 8'(o_bcd_tens), 8'd6);
                chk("c63_ones", 8'(o_bcd_ones), 8'd3);
                chk("c63_seg_ones", 8'(o_seg), 8'h4F);
            end
            if (k == 12) chk("c63_seg_tens", 8'(o_seg), 8'h7D);
            step();
        end
        i_result_valid = 1'b0;

        // ---------------- Convert 10 ----------------
        convert(6'd10);
        chk("c10_tens", 8'(o_bcd_tens), 8'd1);
        chk("c10_ones", 8'(o_bcd_ones), 8'd0);
        wait_sel("c10_wait_tens", 2'b10);
        chk("c10_seg_tens", 8'(o_seg), 8'h06);
        wait_sel("c10_wait_ones", 2'b01);
        chk("c10_seg_ones", 8'(o_seg), 8'h3F);

        // ---------------- Convert 0 ----------------
        convert(6'd0);
        chk("c0_tens", 8'(o_bcd_tens), 8'd0);
        chk("c0_ones", 8'(o_bcd_ones), 8'd0);
        wait_sel("c0_wait_tens", 2'b10);
        chk("c0_seg_tens_blank", 8'(o_seg), 8'h00);
        wait_sel("c0_wait_ones", 2'b01);
        chk("c0_seg_ones", 8'(o_seg), 8'h3F);

        // ---------------- Overrun: 45 then 12 in cycle 3 ----------------
        i_result_in    = 6'd45;
        i_result_valid = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            i_result_valid = (c == 3);
            i_result_in    = (c == 3) ? 6'd12 : 6'd0;
            chk($sformatf("ovr_overrun_c%0d", c), 8'(o_overrun), 8'(c == 4));
            chk($sformatf("ovr_done_c%0d", c), 8'(o_done), 8'(c == 7));
            if (c < 8) step();
        end
        i_result_valid = 1'b0;
        chk("ovr_tens", 8'(o_bcd_tens), 8'd4);
        chk("ovr_ones", 8'(o_bcd_ones), 8'd5);
        chk("ovr_idle", 8'(o_busy), 8'd0);

        // ---------------- Reset mid-conversion of 57 ----------------
        i_result_in    = 6'd57;
        i_result_valid = 1'b1;
        step();
        i_result_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) i_rst_n = 1'b0;
            chk($sformatf("mrst_done_c%0d", c), 8'(o_done), 8'd0);
            chk($sformatf("mrst_busy_c%0d", c), 8'(o_busy), 8'd1);
            step();
        end
        chk("mrst_busy", 8'(o_busy), 8'd0);
        chk("mrst_done", 8'(o_done), 8'd0);
        chk("mrst_overrun", 8'(o_overrun), 8'd0);
        chk("mrst_tens", 8'(o_bcd_tens), 8'd0);
        chk("mrst_ones", 8'(o_bcd_ones), 8'd0);
        chk("mrst_dig_sel", 8'(o_dig_sel), 8'h01);
        chk("mrst_seg", 8'(o_seg), 8'h3F);
        i_rst_n = 1'b1;
        step();

        // ---------------- ena low for cycles 3..7 of a conversion of 38 ----------------
        i_result_in    = 6'd38;
        i_result_valid = 1'b1;
        step();
        i_result_valid = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            i_ena          = !((c >= 3) && (c <= 7));
            // A strobe while disabled must be ignored without an overrun.
            i_result_valid = (c == 5);
            i_result_in    = (c == 5) ? 6'd11 : 6'd0;
            chk($sformatf("ena_busy_c%0d", c), 8'(o_busy), 8'((c >= 1) && (c <= 12)));
            chk($sformatf("ena_done_c%0d", c), 8'(o_done), 8'(c == 12));
            chk($sformatf("ena_overrun_c%0d", c), 8'(o_overrun), 8'd0);
            if (c < 13) step();
        end
        i_ena          = 1'b1;
        i_result_valid = 1'b0;
        chk("ena_tens", 8'(o_bcd_tens), 8'd3);
        chk("ena_ones", 8'(o_bcd_ones), 8'd8);
        wait_sel("ena_wait_tens", 2'b10);
        chk("ena_seg_tens", 8'(o_seg), 8'h4F);
        wait_sel("ena_wait_ones", 2'b01);
        chk("ena_seg_ones", 8'(o_seg), 8'h7F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
